// File: rtl/mac_unit_wave_seq.sv
// rtl/mac_unit_wave_seq.sv - self-sequencing bit-serial sparse-column dot-product MAC
//
// Takes one activation vector through act_valid/act_ready and keeps it in a
// register. Sparse weight bit-columns then arrive through col_valid/col_ready.
// Each column carries its own bit position in col_idx. For every column the
// selected, sign-applied lanes pass through an adder tree. The tree sum is
// shifted by col_idx and added to the accumulator. The column flagged
// col_last ends the vector, and the result is then offered on
// res_valid/res_ready.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   act_valid/act_ready   activation vector handshake, act = VEC_LENGTH lanes
//   col_valid/col_ready   column handshake, sign/w_bit per lane, col_idx, col_last
//   res_valid/res_ready   result handshake, result = accumulated dot product
//   col_count             columns accepted for the current vector (saturating)
module mac_unit_wave_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int W_PREC     = 8,
    localparam int IDX_WIDTH  = $clog2(W_PREC),
    localparam int PSUM_WIDTH = DATA_WIDTH + 1 + $clog2(VEC_LENGTH),
    localparam int RES_WIDTH  = PSUM_WIDTH + W_PREC
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  act_valid,
    output logic                                  act_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
    input  logic                                  col_valid,
    output logic                                  col_ready,
    input  logic [VEC_LENGTH-1:0]                 sign,
    input  logic [VEC_LENGTH-1:0]                 w_bit,
    input  logic [IDX_WIDTH-1:0]                  col_idx,
    input  logic                                  col_last,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic signed [RES_WIDTH-1:0]           result,
    output logic [IDX_WIDTH:0]                    col_count
);

    localparam logic [IDX_WIDTH:0] CNT_MAX = (IDX_WIDTH + 1)'(W_PREC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                                state_q, state_d;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q, act_d;
    logic signed [RES_WIDTH-1:0]           acc_q, acc_d;
    logic signed [RES_WIDTH-1:0]           result_q, result_d;
    logic [IDX_WIDTH:0]                    col_count_q, col_count_d;

    // Heap-ordered adder tree: leaves sit at VEC_LENGTH-1 .. 2*VEC_LENGTH-2.
    // Node i sums nodes 2i+1 and 2i+2. Every node is PSUM_WIDTH wide, so
    // each level adds sign-extended operands and the tree cannot overflow.
    logic signed [PSUM_WIDTH-1:0] tree [2*VEC_LENGTH-1];
    logic signed [DATA_WIDTH:0]   lane_a;
    logic signed [DATA_WIDTH:0]   lane_v;
    logic signed [PSUM_WIDTH-1:0] psum;
    logic signed [RES_WIDTH-1:0]  psum_ext;
    logic signed [RES_WIDTH-1:0]  shifted;
    logic signed [RES_WIDTH-1:0]  acc_sum;

    always_comb begin
        lane_a = '0;
        lane_v = '0;
        for (int i = 0; i < 2*VEC_LENGTH-1; i++) begin
            tree[i] = '0;
        end
        for (int i = 0; i < VEC_LENGTH; i++) begin
            // One extra bit lets the negation of the most negative activation fit.
            lane_a = {act_q[i][DATA_WIDTH-1], act_q[i]};
            if (!w_bit[i]) begin
                lane_v = '0;
            end else if (sign[i]) begin
                lane_v = -lane_a;
            end else begin
                lane_v = lane_a;
            end
            tree[VEC_LENGTH-1+i] = {{(PSUM_WIDTH-DATA_WIDTH-1){lane_v[DATA_WIDTH]}}, lane_v};
        end
        for (int i = VEC_LENGTH-2; i >= 0; i--) begin
            tree[i] = tree[2*i+1] + tree[2*i+2];
        end
        psum     = tree[0];
        psum_ext = {{(RES_WIDTH-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};
        shifted  = psum_ext <<< col_idx;
        acc_sum  = acc_q + shifted;
    end

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        acc_d       = acc_q;
        result_d    = result_q;
        col_count_d = col_count_q;
        act_ready   = 1'b0;
        col_ready   = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    act_d       = act;
                    acc_d       = '0;
                    col_count_d = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                col_ready = 1'b1;
                if (col_valid) begin
                    acc_d = acc_sum;
                    if (col_count_q != CNT_MAX) begin
                        col_count_d = col_count_q + 1'b1;
                    end
                    if (col_last) begin
                        // The result register is loaded only here. It keeps
                        // its stale value through the next IDLE/ACCUM phases.
                        result_d = acc_sum;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            act_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            col_count_q <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            col_count_q <= col_count_d;
        end
    end

    assign result    = result_q;
    assign col_count = col_count_q;

endmodule
